// File: rtl/sim_status_mon.sv
// sim_status_mon - simulation/emulation status monitor.
//
// Watches three things in the SoC and reports how the run ended:
//   * CPU AXI write channel: single-beat writes to CON_ADDR are console
//     characters. They are buffered in a FIFO and drained over con_valid/con_ready.
//   * Write-back buses: a FAIL_VAL or PASS_VAL value ends the run.
//   * Retire strobes: a watchdog window with no retirement ends the run.
//
// Ports
//   clk, rst_b        clock, asynchronous active-low reset
//   retire            per-slot retire strobes
//   wb_data           write-back values, slot i at [64i+:64]
//   aw_* / w_*        AXI AW/W snoop (these signals are observed only, never driven)
//   con_valid/ready   console character handshake, con_char = FIFO head
//   con_drop_cnt      count of characters lost on a full FIFO (saturating)
//   sim_done          run finished and console drained (sticky)
//   sim_status        00 running, 01 pass, 10 fail, 11 watchdog (sticky)
//
// FSM states
//   state | meaning
//   RUN   | normal operation, watching for pass/fail/timeout
//   DRAIN | status latched, waiting for the console path to empty
//   DONE  | sim_done asserted, watchdog frozen, FIFO may still drain

module sim_status_mon #(
    parameter int              DATA_W   = 128,
    parameter int              ADDR_W   = 40,
    parameter int              NUM_RET  = 2,
    parameter int              NUM_WB   = 2,
    parameter logic [ADDR_W-1:0] CON_ADDR = 40'h90000000,
    parameter logic [63:0]     PASS_VAL = 64'h444333222,
    parameter logic [63:0]     FAIL_VAL = 64'h2382348720,
    parameter int              CHK_CYC  = 50000,
    parameter int              FIFO_DEP = 16
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic [NUM_RET-1:0]    retire,
    input  logic [NUM_WB*64-1:0]  wb_data,
    input  logic                  aw_valid,
    input  logic                  aw_ready,
    input  logic [ADDR_W-1:0]     aw_addr,
    input  logic [7:0]            aw_len,
    input  logic                  w_valid,
    input  logic                  w_ready,
    input  logic [DATA_W/8-1:0]   w_strb,
    input  logic [DATA_W-1:0]     w_data,
    output logic                  con_valid,
    input  logic                  con_ready,
    output logic [7:0]            con_char,
    output logic [15:0]           con_drop_cnt,
    output logic                  sim_done,
    output logic [1:0]            sim_status
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LANE_W = $clog2(STRB_W);
    localparam int PTR_W  = $clog2(FIFO_DEP);
    localparam int WIN_W  = $clog2(CHK_CYC);

    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, DONE = 2'd2} state_t;

    state_t state, state_nxt;
    logic [1:0] status, status_nxt;

    // ---------------- console capture ----------------
    logic              aw_hs, w_hs, aw_hit, hit, hit_eff, cap_now;
    logic [LANE_W-1:0] lane;
    logic [7:0]        lane_char;
    logic              cap_valid;
    logic [7:0]        cap_char;

    assign aw_hs   = aw_valid & aw_ready;
    assign w_hs    = w_valid & w_ready;
    assign aw_hit  = (aw_addr == CON_ADDR) && (aw_len == 8'd0);
    // A W beat in the same cycle as an AW handshake belongs to that new AW.
    assign hit_eff = aw_hs ? aw_hit : hit;
    assign cap_now = w_hs && hit_eff && (|w_strb);

    // Lowest enabled byte lane carries the character.
    always_comb begin
        lane = '0;
        for (int i = STRB_W - 1; i >= 0; i--) begin
            if (w_strb[i]) lane = LANE_W'(i);
        end
    end
    assign lane_char = w_data[{lane, 3'b000} +: 8];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            hit       <= 1'b0;
            cap_valid <= 1'b0;
            cap_char  <= 8'h00;
        end else begin
            if (w_hs)       hit <= 1'b0;
            else if (aw_hs) hit <= aw_hit;
            cap_valid <= cap_now;
            if (cap_now) cap_char <= lane_char;
        end
    end

    // ---------------- console FIFO ----------------
    logic [7:0]     mem [FIFO_DEP];
    logic [PTR_W:0] wr_ptr, rd_ptr;
    logic           fifo_empty, fifo_full, pop, push_ok, drop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop        = con_valid && con_ready;
    // A full FIFO still takes a character when the head leaves in the same cycle.
    assign push_ok    = cap_valid && (!fifo_full || pop);
    assign drop       = cap_valid && fifo_full && !pop;

    assign con_valid  = !fifo_empty;
    assign con_char   = fifo_empty ? 8'h00 : mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= cap_char;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            con_drop_cnt <= 16'h0000;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (drop && con_drop_cnt != 16'hFFFF) con_drop_cnt <= con_drop_cnt + 16'd1;
        end
    end

    // ---------------- signature detect ----------------
    logic [NUM_WB*64-1:0] wb_q;
    logic                 sig_fail, sig_pass;

    always_comb begin
        sig_fail = 1'b0;
        sig_pass = 1'b0;
        for (int i = 0; i < NUM_WB; i++) begin
            if (wb_q[64*i +: 64] == FAIL_VAL) sig_fail = 1'b1;
            if (wb_q[64*i +: 64] == PASS_VAL) sig_pass = 1'b1;
        end
    end

    // ---------------- retire watchdog ----------------
    logic [WIN_W-1:0] win_cnt;
    logic [31:0]      ret_cnt, ret_pop;
    logic [32:0]      ret_sum;
    logic             win_wrap, timeout;

    always_comb begin
        ret_pop = '0;
        for (int i = 0; i < NUM_RET; i++) ret_pop = ret_pop + 32'(retire[i]);
    end
    assign ret_sum  = {1'b0, ret_cnt} + {1'b0, ret_pop};
    assign win_wrap = (win_cnt == WIN_W'(CHK_CYC - 1));
    assign timeout  = win_wrap && (ret_cnt == 32'd0) && (ret_pop == 32'd0);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wb_q    <= '0;
            win_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            wb_q <= wb_data;
            if (state != DONE) begin
                if (win_wrap) begin
                    win_cnt <= '0;
                    ret_cnt <= '0;
                end else begin
                    win_cnt <= win_cnt + 1'b1;
                    ret_cnt <= ret_sum[32] ? 32'hFFFF_FFFF : ret_sum[31:0];
                end
            end
        end
    end

    // ---------------- run-state FSM ----------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state  <= RUN;
            status <= 2'b00;
        end else begin
            state  <= state_nxt;
            status <= status_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        status_nxt = status;
        case (state)
            RUN: begin
                if (sig_fail) begin
                    status_nxt = 2'b10;
                    state_nxt  = DRAIN;
                end else if (sig_pass) begin
                    status_nxt = 2'b01;
                    state_nxt  = DRAIN;
                end else if (timeout) begin
                    status_nxt = 2'b11;
                    state_nxt  = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty && !cap_valid && !cap_now) state_nxt = DONE;
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = RUN;
        endcase
    end

    assign sim_done   = (state == DONE);
    assign sim_status = status;

endmodule

// File: tb/tb_sim_status_mon.sv
module tb_sim_status_mon;

    localparam logic [39:0] CON      = 40'h90000000;
    localparam logic [63:0] SIG_PASS = 64'h444333222;
    localparam logic [63:0] SIG_FAIL = 64'h2382348720;

    logic         clk = 1'b0;
    logic         rst_b;
    logic [1:0]   retire;
    logic [127:0] wb_data;
    logic         aw_valid, aw_ready;
    logic [39:0]  aw_addr;
    logic [7:0]   aw_len;
    logic         w_valid, w_ready;
    logic [15:0]  w_strb;
    logic [127:0] w_data;
    logic         con_valid, con_ready;
    logic [7:0]   con_char;
    logic [15:0]  con_drop_cnt;
    logic         sim_done;
    logic [1:0]   sim_status;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    sim_status_mon #(.CHK_CYC(100), .FIFO_DEP(16)) dut (
        .clk(clk), .rst_b(rst_b), .retire(retire), .wb_data(wb_data),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
        .w_valid(w_valid), .w_ready(w_ready), .w_strb(w_strb), .w_data(w_data),
        .con_valid(con_valid), .con_ready(con_ready), .con_char(con_char),
        .con_drop_cnt(con_drop_cnt), .sim_done(sim_done), .sim_status(sim_status)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] make_data(input int lane, input logic [7:0] ch);
        logic [127:0] d;
        for (int j = 0; j < 16; j++) d[8*j +: 8] = ~ch;
        d[8*lane +: 8] = ch;
        return d;
    endfunction

    // Called just after a rising edge; returns just after the edge that took the W beat.
    task automatic axi_wr(input logic [39:0] addr, input logic [7:0] len, input logic [15:0] strb,
                          input logic [127:0] data, input bit split);
        aw_valid = 1'b1; aw_ready = 1'b1; aw_addr = addr; aw_len = len;
        if (!split) begin
            w_valid = 1'b1; w_ready = 1'b1; w_strb = strb; w_data = data;
        end
        tick();
        aw_valid = 1'b0; aw_ready = 1'b0;
        if (split) begin
            w_valid = 1'b1; w_ready = 1'b1; w_strb = strb; w_data = data;
            tick();
        end
        w_valid = 1'b0; w_ready = 1'b0;
    endtask

    task automatic drain(input int cycles, input string tag);
        con_ready = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (con_valid) begin
                if (exp_q.size() == 0) chk({tag, "_unexpected_pop"}, 64'(con_valid), 64'd0);
                else                   chk({tag, "_char"}, 64'(con_char), 64'(exp_q.pop_front()));
            end
        end
        chk({tag, "_missing"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_b = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    initial begin
        rst_b = 1'b0; retire = 2'b01; wb_data = '0;
        aw_valid = 1'b0; aw_ready = 1'b0; aw_addr = '0; aw_len = '0;
        w_valid = 1'b0; w_ready = 1'b0; w_strb = '0; w_data = '0; con_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid",  64'(con_valid), 64'd0);
        chk("rst_char",   64'(con_char), 64'd0);
        chk("rst_drop",   64'(con_drop_cnt), 64'd0);
        chk("rst_done",   64'(sim_done), 64'd0);
        chk("rst_status", 64'(sim_status), 64'd0);
        rst_b = 1'b1;
        tick();

        // single console write, char in lane 4
        con_ready = 1'b1;
        axi_wr(CON, 8'd0, 16'h00F0, make_data(4, 8'h41), 1'b0);
        exp_q.push_back(8'h41);
        drain(8, "t1");
        chk("t1_drop", 64'(con_drop_cnt), 64'd0);
        tick();

        // AW and W in separate cycles; a second W beat without a new AW is not console
        axi_wr(CON, 8'd0, 16'h0001, make_data(0, 8'h42), 1'b1);
        exp_q.push_back(8'h42);
        w_valid = 1'b1; w_ready = 1'b1; w_strb = 16'h0001; w_data = make_data(0, 8'h43);
        tick();
        w_valid = 1'b0; w_ready = 1'b0;
        drain(8, "t1b");
        tick();

        // non-console writes: burst, wrong address, no strobes
        axi_wr(CON, 8'd1, 16'h0001, make_data(0, 8'h44), 1'b0);
        axi_wr(CON + 40'd4, 8'd0, 16'h0001, make_data(0, 8'h45), 1'b0);
        axi_wr(CON, 8'd0, 16'h0000, make_data(0, 8'h46), 1'b0);
        drain(8, "t2");
        chk("t2_valid", 64'(con_valid), 64'd0);
        tick();

        // fill FIFO with consumer stalled: 17 writes, 16 kept, one dropped
        con_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            axi_wr(CON, 8'd0, 16'(16'hFFFF << (i % 16)), make_data(i % 16, 8'h61 + 8'(i)), 1'b0);
            if (i < 16) exp_q.push_back(8'h61 + 8'(i));
        end
        tick(); tick(); tick();
        chk("t3_drop",  64'(con_drop_cnt), 64'd1);
        chk("t3_valid", 64'(con_valid), 64'd1);
        chk("t3_head",  64'(con_char), 64'(exp_q[0]));
        tick();
        chk("t3_hold",  64'(con_char), 64'(exp_q[0]));
        // push into a full FIFO while the head is popped in the same cycle
        axi_wr(CON, 8'd0, 16'h0001, make_data(0, 8'h7A), 1'b0);
        con_ready = 1'b1;
        exp_q.push_back(8'h7A);
        drain(24, "t3");
        chk("t3_drop_after", 64'(con_drop_cnt), 64'd1);
        tick();

        // watchdog: no retirement in the first window
        retire = 2'b00;
        reset_dut();
        repeat (99) @(posedge clk);
        @(negedge clk);
        chk("t5_pre_wrap", 64'(sim_status), 64'd0);
        @(negedge clk);
        chk("t5_timeout", 64'(sim_status), 64'd3);
        chk("t5_done_lag", 64'(sim_done), 64'd0);
        @(negedge clk);
        chk("t5_done", 64'(sim_done), 64'd1);

        // watchdog: a single retire in the wrap cycle keeps the run alive
        retire = 2'b00;
        reset_dut();
        repeat (99) @(posedge clk);
        #1 retire = 2'b01;
        @(posedge clk);
        #1 retire = 2'b11;
        @(negedge clk);
        chk("t5b_no_timeout", 64'(sim_status), 64'd0);
        repeat (100) @(negedge clk);
        chk("t5b_later", 64'(sim_status), 64'd0);

        // fail and pass in the same cycle, chars queued
        reset_dut();
        tick();
        con_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            axi_wr(CON, 8'd0, 16'h0001, make_data(0, 8'h78 + 8'(i)), 1'b0);
            exp_q.push_back(8'h78 + 8'(i));
        end
        tick();
        wb_data = {SIG_PASS, SIG_FAIL};
        tick();
        wb_data = '0;
        @(negedge clk);
        chk("t4_early", 64'(sim_status), 64'd0);
        @(negedge clk);
        chk("t4_status", 64'(sim_status), 64'd2);
        chk("t4_not_done", 64'(sim_done), 64'd0);
        chk("t4_queued", 64'(con_valid), 64'd1);
        tick();
        wb_data = {SIG_PASS, 64'h0};
        tick();
        wb_data = '0;
        repeat (3) tick();
        chk("t4_sticky", 64'(sim_status), 64'd2);

        // asynchronous reset in DRAIN
        @(posedge clk);
        #3 rst_b = 1'b0;
        #1;
        chk("t6_valid",  64'(con_valid), 64'd0);
        chk("t6_status", 64'(sim_status), 64'd0);
        chk("t6_done",   64'(sim_done), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_b = 1'b1;

        // fail wins with slots swapped; sim_done only after the FIFO empties
        tick();
        con_ready = 1'b0;
        axi_wr(CON, 8'd0, 16'h0001, make_data(0, 8'h70), 1'b0);
        exp_q.push_back(8'h70);
        axi_wr(CON, 8'd0, 16'h0001, make_data(0, 8'h71), 1'b0);
        exp_q.push_back(8'h71);
        tick();
        wb_data = {SIG_FAIL, SIG_PASS};
        tick();
        wb_data = '0;
        repeat (5) tick();
        chk("t4b_status", 64'(sim_status), 64'd2);
        chk("t4b_waiting", 64'(sim_done), 64'd0);
        drain(10, "t4b");
        chk("t4b_done", 64'(sim_done), 64'd1);
        chk("t4b_empty", 64'(con_valid), 64'd0);

        // pass alone
        reset_dut();
        tick();
        wb_data = {64'h0, SIG_PASS};
        tick();
        wb_data = '0;
        @(negedge clk);
        @(negedge clk);
        chk("t4c_pass", 64'(sim_status), 64'd1);
        @(negedge clk);
        chk("t4c_done", 64'(sim_done), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
